// File: rtl/muldiv_controller_pkg.sv
// Shared encodings for the M-extension multiply/divide unit.
// Covers FUNCT3 opcodes, FSM states, default width and opcode-class helpers.
package muldiv_controller_pkg;

   localparam int XLEN_DEF = 32;

   localparam logic [2:0] F3_MUL    = 3'b000;
   localparam logic [2:0] F3_MULH   = 3'b001;
   localparam logic [2:0] F3_MULHSU = 3'b010;
   localparam logic [2:0] F3_MULHU  = 3'b011;
   localparam logic [2:0] F3_DIV    = 3'b100;
   localparam logic [2:0] F3_DIVU   = 3'b101;
   localparam logic [2:0] F3_REM    = 3'b110;
   localparam logic [2:0] F3_REMU   = 3'b111;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_MUL,
      ST_DIV,
      ST_FIX,
      ST_DONE
   } state_t;

   function automatic logic is_div(input logic [2:0] f3);
      return (f3 == F3_DIV) || (f3 == F3_DIVU) || (f3 == F3_REM) || (f3 == F3_REMU);
   endfunction

   function automatic logic is_div_signed(input logic [2:0] f3);
      return (f3 == F3_DIV) || (f3 == F3_REM);
   endfunction

   function automatic logic is_rem(input logic [2:0] f3);
      return (f3 == F3_REM) || (f3 == F3_REMU);
   endfunction

endpackage

// File: rtl/muldiv_multiplier.sv
// Combinational 33x33 signed multiplier; each operand is sign- or zero-extended by FUNCT3.
// Returns the low product word for MUL and the high word for MULH/MULHSU/MULHU.
module muldiv_multiplier
   import muldiv_controller_pkg::*;
#(
   parameter int XLEN = XLEN_DEF
) (
   input  logic [2:0]      i_funct3,
   input  logic [XLEN-1:0] i_a,
   input  logic [XLEN-1:0] i_b,
   output logic [XLEN-1:0] o_result
);

   logic              w_a_signed;
   logic              w_b_signed;
   logic              w_high;
   logic [XLEN:0]     w_a_ext;
   logic [XLEN:0]     w_b_ext;
   logic [2*XLEN-1:0] w_a_wide;
   logic [2*XLEN-1:0] w_b_wide;
   logic [2*XLEN-1:0] w_prod;

   assign w_a_signed = (i_funct3 == F3_MULH) || (i_funct3 == F3_MULHSU);
   assign w_b_signed = (i_funct3 == F3_MULH);
   assign w_high     = (i_funct3 == F3_MULH) || (i_funct3 == F3_MULHSU) || (i_funct3 == F3_MULHU);

   assign w_a_ext = {w_a_signed & i_a[XLEN-1], i_a};
   assign w_b_ext = {w_b_signed & i_b[XLEN-1], i_b};

   // Product modulo 2^(2*XLEN) of the 33-bit values is exact for the bits we return.
   assign w_a_wide = {{(XLEN-1){w_a_ext[XLEN]}}, w_a_ext};
   assign w_b_wide = {{(XLEN-1){w_b_ext[XLEN]}}, w_b_ext};
   assign w_prod   = w_a_wide * w_b_wide;

   assign o_result = w_high ? w_prod[2*XLEN-1:XLEN] : w_prod[XLEN-1:0];

endmodule

// File: rtl/muldiv_controller.sv
// M-extension multiply/divide controller: MUL done 2 cycles after START, restoring divide 34, /0 and overflow 1.
// BUSY stalls the pipeline while working; START is accepted only in IDLE or DONE, FLUSH abandons the operation.
module muldiv_controller
   import muldiv_controller_pkg::*;
#(
   parameter int XLEN = XLEN_DEF
) (
   input  logic            CLK,
   input  logic            RESET,
   input  logic            START,
   input  logic [2:0]      FUNCT3,
   input  logic [XLEN-1:0] OPERAND_A,
   input  logic [XLEN-1:0] OPERAND_B,
   input  logic            FLUSH,
   output logic            BUSY,
   output logic            DONE,
   output logic [XLEN-1:0] RESULT
);

   localparam int            CW       = $clog2(XLEN);
   localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);

   state_t          r_state;
   state_t          w_next;
   logic [2:0]      r_funct3;
   logic [XLEN-1:0] r_op_a;
   logic [XLEN-1:0] r_op_b;
   logic [XLEN-1:0] r_quot;
   logic [XLEN-1:0] r_rem;
   logic [XLEN-1:0] r_divisor;
   logic [XLEN-1:0] r_result;
   logic [CW-1:0]   r_cnt;
   logic            r_neg_q;
   logic            r_neg_r;

   logic            w_accept;
   logic            w_div_op;
   logic            w_signed;
   logic            w_a_neg;
   logic            w_b_neg;
   logic [XLEN-1:0] w_a_mag;
   logic [XLEN-1:0] w_b_mag;
   logic            w_div_zero;
   logic            w_overflow;
   logic            w_early;
   logic [XLEN-1:0] w_early_res;
   logic [XLEN-1:0] w_mul_res;
   logic [XLEN:0]   w_rem_shift;
   logic            w_ge;
   logic [XLEN-1:0] w_diff;
   logic [XLEN-1:0] w_fix_res;

   assign w_accept = ((r_state == ST_IDLE) || (r_state == ST_DONE)) && START && !FLUSH;
   assign w_div_op = is_div(FUNCT3);
   assign w_signed = is_div_signed(FUNCT3);
   assign w_a_neg  = w_signed & OPERAND_A[XLEN-1];
   assign w_b_neg  = w_signed & OPERAND_B[XLEN-1];
   assign w_a_mag  = w_a_neg ? -OPERAND_A : OPERAND_A;
   assign w_b_mag  = w_b_neg ? -OPERAND_B : OPERAND_B;

   // Zero divisor and signed overflow bypass the iteration; the overflow quotient equals A itself.
   assign w_div_zero  = (OPERAND_B == '0);
   assign w_overflow  = w_signed && (OPERAND_A == {1'b1, {(XLEN-1){1'b0}}}) && (OPERAND_B == '1);
   assign w_early     = w_div_op && (w_div_zero || w_overflow);
   assign w_early_res = w_div_zero ? (is_rem(FUNCT3) ? OPERAND_A : '1)
                                   : (is_rem(FUNCT3) ? '0 : OPERAND_A);

   muldiv_multiplier #(.XLEN(XLEN)) u_mul (
      .i_funct3 (r_funct3),
      .i_a      (r_op_a),
      .i_b      (r_op_b),
      .o_result (w_mul_res)
   );

   // One restoring step: shift the next dividend bit in, subtract when it fits.
   assign w_rem_shift = {r_rem, r_quot[XLEN-1]};
   assign w_ge        = (w_rem_shift >= {1'b0, r_divisor});
   assign w_diff      = w_rem_shift[XLEN-1:0] - r_divisor;

   assign w_fix_res = is_rem(r_funct3) ? (r_neg_r ? -r_rem : r_rem)
                                       : (r_neg_q ? -r_quot : r_quot);

   always_ff @(posedge CLK) begin
      if (RESET) r_state <= ST_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         ST_IDLE, ST_DONE: begin
            w_next = ST_IDLE;
            if (START) begin
               if (!w_div_op)   w_next = ST_MUL;
               else if (w_early) w_next = ST_DONE;
               else             w_next = ST_DIV;
            end
         end
         ST_MUL:  w_next = ST_DONE;
         ST_DIV:  if (r_cnt == '0) w_next = ST_FIX;
         ST_FIX:  w_next = ST_DONE;
         default: w_next = ST_IDLE;
      endcase
      if (FLUSH) w_next = ST_IDLE;
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_funct3  <= '0;
         r_op_a    <= '0;
         r_op_b    <= '0;
         r_quot    <= '0;
         r_rem     <= '0;
         r_divisor <= '0;
         r_result  <= '0;
         r_cnt     <= '0;
         r_neg_q   <= 1'b0;
         r_neg_r   <= 1'b0;
      end else if (w_accept) begin
         r_funct3  <= FUNCT3;
         r_op_a    <= OPERAND_A;
         r_op_b    <= OPERAND_B;
         r_quot    <= w_a_mag;
         r_rem     <= '0;
         r_divisor <= w_b_mag;
         r_cnt     <= CNT_LAST;
         r_neg_q   <= w_a_neg ^ w_b_neg;
         r_neg_r   <= w_a_neg;
         if (w_early) r_result <= w_early_res;
      end else if (!FLUSH) begin
         unique case (r_state)
            ST_MUL: r_result <= w_mul_res;
            ST_DIV: begin
               r_rem  <= w_ge ? w_diff : w_rem_shift[XLEN-1:0];
               r_quot <= {r_quot[XLEN-2:0], w_ge};
               r_cnt  <= r_cnt - CW'(1);
            end
            ST_FIX: r_result <= w_fix_res;
            default: ;
         endcase
      end
   end

   assign BUSY   = (r_state == ST_MUL) || (r_state == ST_DIV) || (r_state == ST_FIX);
   assign DONE   = (r_state == ST_DONE);
   assign RESULT = r_result;

endmodule

// File: tb/tb_muldiv_controller.sv
// Directed bench for muldiv_controller: latency, results, special divides, flush, reset and back-to-back issue.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_muldiv_controller;

   logic        CLK;
   logic        RESET;
   logic        START;
   logic [2:0]  FUNCT3;
   logic [31:0] OPERAND_A;
   logic [31:0] OPERAND_B;
   logic        FLUSH;
   logic        BUSY;
   logic        DONE;
   logic [31:0] RESULT;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
   } vec_t;

   muldiv_controller #(.XLEN(32)) dut (
      .CLK       (CLK),
      .RESET     (RESET),
      .START     (START),
      .FUNCT3    (FUNCT3),
      .OPERAND_A (OPERAND_A),
      .OPERAND_B (OPERAND_B),
      .FLUSH     (FLUSH),
      .BUSY      (BUSY),
      .DONE      (DONE),
      .RESULT    (RESULT)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Issues one op at the current falling edge (cycle 0) and waits, bounded, for DONE.
   task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         output int dcyc, output logic [31:0] res, output int bcnt);
      START = 1'b1; FUNCT3 = f3; OPERAND_A = a; OPERAND_B = b;
      dcyc = -1; res = '0; bcnt = 0;
      for (int n = 1; n <= 100 && dcyc < 0; n++) begin
         @(negedge CLK);
         START = 1'b0;
         if (BUSY) bcnt++;
         if (DONE) begin
            dcyc = n;
            res  = RESULT;
         end
      end
   endtask

   task automatic test_reset;
      repeat (2) @(negedge CLK);
      checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", BUSY); end
      checks++; if (DONE !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", DONE); end
      checks++; if (RESULT !== 32'h0) begin errors++; $display("FAIL reset_result: got %h expected 00000000", RESULT); end
      RESET = 1'b0;
      @(negedge CLK);
      checks++; if (DONE !== 1'b0 || BUSY !== 1'b0) begin errors++; $display("FAIL post_reset_idle: got busy=%b done=%b expected 0 0", BUSY, DONE); end
   endtask

   task automatic test_mul;
      vec_t v [7];
      int dcyc, bcnt;
      logic [31:0] res;
      v[0] = '{3'b001, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF};
      v[1] = '{3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001};
      v[2] = '{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE};
      v[3] = '{3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000};
      v[4] = '{3'b010, 32'h00000002, 32'hFFFFFFFF, 32'h00000001};
      v[5] = '{3'b001, 32'h80000000, 32'h80000000, 32'h40000000};
      v[6] = '{3'b000, 32'h00003039, 32'h00000064, 32'h0012D644};
      for (int i = 0; i < 7; i++) begin
         @(negedge CLK);
         run_op(v[i].f3, v[i].a, v[i].b, dcyc, res, bcnt);
         checks++; if (dcyc !== 2) begin errors++; $display("FAIL mul[%0d]_latency: got %0d expected 2", i, dcyc); end
         checks++; if (res !== v[i].exp) begin errors++; $display("FAIL mul[%0d]_result: got %h expected %h", i, res, v[i].exp); end
         checks++; if (bcnt !== 1) begin errors++; $display("FAIL mul[%0d]_busy_cycles: got %0d expected 1", i, bcnt); end
      end
   endtask

   task automatic test_div;
      vec_t v [10];
      int dcyc, bcnt;
      logic [31:0] res;
      v[0] = '{3'b100, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD};
      v[1] = '{3'b110, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF};
      v[2] = '{3'b101, 32'd100,      32'd7,        32'd14};
      v[3] = '{3'b111, 32'd100,      32'd7,        32'd2};
      v[4] = '{3'b100, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD};
      v[5] = '{3'b110, 32'h00000007, 32'hFFFFFFFE, 32'h00000001};
      v[6] = '{3'b110, 32'hFFFFFFF8, 32'hFFFFFFFD, 32'hFFFFFFFE};
      v[7] = '{3'b101, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF};
      v[8] = '{3'b111, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F};
      v[9] = '{3'b101, 32'h80000000, 32'hFFFFFFFF, 32'h00000000};
      for (int i = 0; i < 10; i++) begin
         @(negedge CLK);
         run_op(v[i].f3, v[i].a, v[i].b, dcyc, res, bcnt);
         checks++; if (dcyc !== 34) begin errors++; $display("FAIL div[%0d]_latency: got %0d expected 34", i, dcyc); end
         checks++; if (res !== v[i].exp) begin errors++; $display("FAIL div[%0d]_result: got %h expected %h", i, res, v[i].exp); end
         checks++; if (bcnt !== 33) begin errors++; $display("FAIL div[%0d]_busy_cycles: got %0d expected 33", i, bcnt); end
      end
   endtask

   task automatic test_div_special;
      vec_t v [6];
      int dcyc, bcnt;
      logic [31:0] res;
      v[0] = '{3'b101, 32'h00000005, 32'h00000000, 32'hFFFFFFFF};
      v[1] = '{3'b111, 32'h00000005, 32'h00000000, 32'h00000005};
      v[2] = '{3'b100, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFFF};
      v[3] = '{3'b110, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9};
      v[4] = '{3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000};
      v[5] = '{3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000};
      for (int i = 0; i < 6; i++) begin
         @(negedge CLK);
         run_op(v[i].f3, v[i].a, v[i].b, dcyc, res, bcnt);
         checks++; if (dcyc !== 1) begin errors++; $display("FAIL special[%0d]_latency: got %0d expected 1", i, dcyc); end
         checks++; if (res !== v[i].exp) begin errors++; $display("FAIL special[%0d]_result: got %h expected %h", i, res, v[i].exp); end
         checks++; if (bcnt !== 0) begin errors++; $display("FAIL special[%0d]_busy_cycles: got %0d expected 0", i, bcnt); end
      end
   endtask

   task automatic test_flush;
      int dcyc, bcnt;
      logic [31:0] res;
      @(negedge CLK);
      run_op(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, dcyc, res, bcnt);
      checks++; if (res !== 32'hFFFFFFFE) begin errors++; $display("FAIL flush_setup_result: got %h expected fffffffe", res); end
      @(negedge CLK);
      START = 1'b1; FUNCT3 = 3'b101; OPERAND_A = 32'd1000; OPERAND_B = 32'd3;
      for (int n = 1; n <= 10; n++) begin
         @(negedge CLK);
         START = 1'b0;
      end
      FLUSH = 1'b1;
      @(negedge CLK);
      FLUSH = 1'b0;
      checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL flush_busy: got %b expected 0", BUSY); end
      checks++; if (DONE !== 1'b0) begin errors++; $display("FAIL flush_done: got %b expected 0", DONE); end
      checks++; if (RESULT !== 32'hFFFFFFFE) begin errors++; $display("FAIL flush_result_held: got %h expected fffffffe", RESULT); end
      @(negedge CLK);
      checks++; if (DONE !== 1'b0 || BUSY !== 1'b0) begin errors++; $display("FAIL flush_still_idle: got busy=%b done=%b expected 0 0", BUSY, DONE); end
      run_op(3'b011, 32'h80000000, 32'h00000002, dcyc, res, bcnt);
      checks++; if (dcyc !== 2) begin errors++; $display("FAIL flush_next_latency: got %0d expected 2", dcyc); end
      checks++; if (res !== 32'h00000001) begin errors++; $display("FAIL flush_next_result: got %h expected 00000001", res); end
   endtask

   task automatic test_reset_mid_div;
      int dcyc, bcnt;
      logic [31:0] res;
      @(negedge CLK);
      START = 1'b1; FUNCT3 = 3'b100; OPERAND_A = 32'hFFFFFFF9; OPERAND_B = 32'd2;
      for (int n = 1; n <= 20; n++) begin
         @(negedge CLK);
         START = 1'b0;
      end
      RESET = 1'b1;
      @(negedge CLK);
      RESET = 1'b0;
      checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b expected 0", BUSY); end
      checks++; if (DONE !== 1'b0) begin errors++; $display("FAIL rst_mid_done: got %b expected 0", DONE); end
      checks++; if (RESULT !== 32'h0) begin errors++; $display("FAIL rst_mid_result: got %h expected 00000000", RESULT); end
      run_op(3'b000, 32'd3, 32'd5, dcyc, res, bcnt);
      checks++; if (res !== 32'd15 || dcyc !== 2) begin errors++; $display("FAIL rst_mid_next_op: got %h at cycle %0d expected 0000000f at cycle 2", res, dcyc); end
   endtask

   task automatic test_back_to_back;
      int dcyc;
      logic [31:0] res;
      @(negedge CLK);
      START = 1'b1; FUNCT3 = 3'b000; OPERAND_A = 32'd3; OPERAND_B = 32'd5;
      @(negedge CLK);
      START = 1'b0;
      checks++; if (BUSY !== 1'b1) begin errors++; $display("FAIL b2b_c1_busy: got %b expected 1", BUSY); end
      @(negedge CLK);
      checks++; if (DONE !== 1'b1 || RESULT !== 32'd15) begin errors++; $display("FAIL b2b_first: got done=%b result=%h expected 1 0000000f", DONE, RESULT); end
      START = 1'b1; OPERAND_A = 32'd6; OPERAND_B = 32'd7;
      @(negedge CLK);
      START = 1'b0;
      checks++; if (DONE !== 1'b0 || BUSY !== 1'b1) begin errors++; $display("FAIL b2b_c3_state: got busy=%b done=%b expected 1 0", BUSY, DONE); end
      checks++; if (RESULT !== 32'd15) begin errors++; $display("FAIL b2b_c3_result_held: got %h expected 0000000f", RESULT); end
      @(negedge CLK);
      checks++; if (DONE !== 1'b1 || RESULT !== 32'd42) begin errors++; $display("FAIL b2b_second: got done=%b result=%h expected 1 0000002a", DONE, RESULT); end
      // START while dividing must be ignored.
      @(negedge CLK);
      START = 1'b1; FUNCT3 = 3'b101; OPERAND_A = 32'd100; OPERAND_B = 32'd7;
      dcyc = -1; res = '0;
      for (int n = 1; n <= 60 && dcyc < 0; n++) begin
         @(negedge CLK);
         START = (n == 5);
         if (n == 5) begin FUNCT3 = 3'b000; OPERAND_A = 32'd9; OPERAND_B = 32'd9; end
         if (DONE) begin dcyc = n; res = RESULT; end
      end
      START = 1'b0;
      checks++; if (dcyc !== 34) begin errors++; $display("FAIL busy_start_latency: got %0d expected 34", dcyc); end
      checks++; if (res !== 32'd14) begin errors++; $display("FAIL busy_start_result: got %h expected 0000000e", res); end
   endtask

   task automatic test_flush_start;
      @(negedge CLK);
      START = 1'b1; FLUSH = 1'b1; FUNCT3 = 3'b000; OPERAND_A = 32'd2; OPERAND_B = 32'd2;
      @(negedge CLK);
      START = 1'b0; FLUSH = 1'b0;
      checks++; if (BUSY !== 1'b0 || DONE !== 1'b0) begin errors++; $display("FAIL flush_start_c1: got busy=%b done=%b expected 0 0", BUSY, DONE); end
      @(negedge CLK);
      checks++; if (BUSY !== 1'b0 || DONE !== 1'b0) begin errors++; $display("FAIL flush_start_c2: got busy=%b done=%b expected 0 0", BUSY, DONE); end
      checks++; if (RESULT !== 32'd14) begin errors++; $display("FAIL flush_start_result: got %h expected 0000000e", RESULT); end
   endtask

   initial begin
      RESET = 1'b1; START = 1'b0; FLUSH = 1'b0;
      FUNCT3 = 3'b000; OPERAND_A = '0; OPERAND_B = '0;
      test_reset;
      test_mul;
      test_div;
      test_div_special;
      test_flush;
      test_reset_mid_div;
      test_back_to_back;
      test_flush_start;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/muldiv_controller.md
MULDIV_CONTROLLER -- requirements
Module: muldiv_controller

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width; only 32 is required to work.
REQ-002 SHALL have port CLK  input  1  rising-edge clock; the block has one clock only.
REQ-003 SHALL have port RESET  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port START  input  1  request to begin an M-extension operation.
REQ-005 SHALL have port FUNCT3  input  3  operation: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 SHALL have port OPERAND_A  input  XLEN  rs1 value (dividend or multiplicand).
REQ-007 SHALL have port OPERAND_B  input  XLEN  rs2 value (divisor or multiplier).
REQ-008 SHALL have port FLUSH  input  1  pipeline flush; abandons any operation in progress.
REQ-009 SHALL have port BUSY  output  1  operation in progress; the pipeline stalls the EX stage while it is high.
REQ-010 SHALL have port DONE  output  1  one-cycle pulse; RESULT is valid in this cycle.
REQ-011 SHALL have port RESULT  output  XLEN  registered result; holds until the next accepted START.

Function
REQ-012 SHALL implement FSM states IDLE, MUL, DIV, FIX, DONE.
REQ-013 SHALL accept START only in IDLE or DONE, latching FUNCT3 and both operands at that edge; START in any other state SHALL be ignored.
REQ-014 Multiply ops SHALL take the path IDLE->MUL->DONE: START in cycle 0, DONE in cycle 2.
REQ-015 MUL SHALL produce product[31:0]; MULH signed x signed [63:32]; MULHSU signed x unsigned [63:32]; MULHU unsigned x unsigned [63:32].
REQ-016 Divide ops SHALL take the path IDLE->DIV (32 cycles, one restoring radix-2 quotient bit per cycle)->FIX->DONE: START in cycle 0, DONE in cycle 34.
REQ-017 For DIV and REM, the block SHALL divide operand magnitudes; FIX SHALL negate the quotient when the operand signs differ and negate the remainder when the dividend is negative.
REQ-018 Divide by zero SHALL go from IDLE straight to DONE (DONE in cycle 1): quotient = 0xFFFFFFFF for DIV/DIVU; remainder = OPERAND_A for REM/REMU.
REQ-019 Signed overflow (DIV/REM with A=0x80000000, B=0xFFFFFFFF) SHALL go from IDLE straight to DONE: quotient = 0x80000000, remainder = 0.
REQ-020 An iteration counter SHALL count 31 down to 0; DIV->FIX SHALL occur on the edge where the counter is 0.
REQ-021 BUSY SHALL be 1 exactly in states MUL, DIV and FIX, and 0 in IDLE and DONE.
REQ-022 DONE SHALL be 1 only in state DONE.
REQ-023 DONE SHALL return to IDLE, or to MUL/DIV/DONE if START is high in that cycle, giving back-to-back issue.
REQ-024 FLUSH SHALL force IDLE on the next edge from any state: no DONE, RESULT unchanged.
REQ-025 FLUSH together with START SHALL keep the block in IDLE; START is dropped.
REQ-026 RESULT SHALL change only on the edge that enters DONE.

Reset
REQ-027 RESET SHALL be sampled on the CLK rising edge only.
REQ-028 RESET SHALL take priority over FLUSH and START.
REQ-029 RESET SHALL return the FSM to IDLE from any state, including mid-division.
REQ-030 After RESET, BUSY=0, DONE=0, RESULT=0, and the counter and all operand/partial registers SHALL be 0.

Structure
REQ-031 A shared package SHALL hold the FUNCT3 encoding constants, the FSM state encoding, and the XLEN default.
REQ-032 The 33x33 signed multiplier (operands sign- or zero-extended per FUNCT3) SHALL be the sub-module muldiv_multiplier.
REQ-033 The divide iteration and FSM SHALL stay in muldiv_controller.

Verification
REQ-034 MULH with A=0xFFFFFFFE (-2), B=3 SHALL give DONE in cycle 2 with RESULT=0xFFFFFFFF, and BUSY high in cycle 1 only.
REQ-035 DIV with A=-7 (0xFFFFFFF9), B=2 SHALL give DONE in cycle 34 with RESULT=0xFFFFFFFD; REM with the same operands SHALL give RESULT=0xFFFFFFFF.
REQ-036 DIVU with A=5, B=0 SHALL give DONE in cycle 1 with RESULT=0xFFFFFFFF; REMU with the same operands SHALL give RESULT=5.
REQ-037 DIV with A=0x80000000, B=0xFFFFFFFF SHALL give RESULT=0x80000000; REM with the same operands SHALL give RESULT=0.
REQ-038 FLUSH asserted in cycle 10 of a DIVU SHALL give IDLE in cycle 11, no DONE pulse, and RESULT unchanged; a new MULHU started in cycle 12 SHALL complete normally.
REQ-039 RESET asserted in cycle 20 of a DIV SHALL give BUSY=0, DONE=0, RESULT=0 in cycle 21.
REQ-040 START held high in the DONE cycle of a MUL SHALL begin the next MUL immediately (its DONE 2 cycles later).
